// File: rtl/seg_display_pkg.sv
// Shared constants and state type for the seven-segment display arbiter.
package seg_display_pkg;

  localparam int unsigned DIGIT_W    = 5;
  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned NUM_REQ    = 3;
  localparam int unsigned DATA_W     = DIGIT_W * NUM_DIGITS;

  localparam logic [DIGIT_W-1:0] CODE_BLANK = 5'd31;
  localparam logic [DIGIT_W-1:0] CODE_DASH  = 5'd10;
  localparam logic [DIGIT_W-1:0] CODE_E     = 5'd11;
  localparam logic [DIGIT_W-1:0] CODE_R     = 5'd12;

  // Every digit blank: what the display shows out of reset and in blink-off phases.
  localparam logic [DATA_W-1:0] BLANK_DATA = {NUM_DIGITS{CODE_BLANK}};

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

endpackage

// File: rtl/seg_hold_timer.sv
// Clear/enable up-counter that stops at LIMIT-1 and flags expiry there.
module seg_hold_timer #(
  parameter int unsigned LIMIT = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CNT_W-1:0] count;

  assign expire = (count == CNT_W'(LIMIT - 1));

  // Count while enabled; hold at the terminal value so the counter never wraps.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !expire) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seg_display_arbiter.sv
// Arbitrates the 4-digit display between a background source and three
// priority-ordered message requesters, holding each granted message for
// HOLD_CYCLES clocks. Optional blinking: define SEG_DISPLAY_ARBITER_BLINK_EN.
module seg_display_arbiter
  import seg_display_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 100_000_000,
  parameter int unsigned BLINK_HALF  = 25_000_000
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [DATA_W-1:0]              base_data,
  input  logic [NUM_DIGITS-1:0]          base_dp,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*DATA_W-1:0]      req_data,
  input  logic [NUM_REQ*NUM_DIGITS-1:0]  req_dp,
  input  logic [NUM_REQ-1:0]             req_blink,
  output logic [NUM_REQ-1:0]             grant,
  output logic [NUM_REQ-1:0]             done,
  output logic                           busy,
  output logic [DATA_W-1:0]              seg_data,
  output logic [NUM_DIGITS-1:0]          dp_data
);

  localparam logic [NUM_REQ-1:0] ONE_REQ = 1;

  state_t                state, state_n;
  logic [NUM_REQ-1:0]    grant_n, done_n, win, higher;
  logic [DATA_W-1:0]     seg_n, win_data;
  logic [NUM_DIGITS-1:0] dp_n, win_dp;
  logic                  take, hold_clr, hold_expire, in_hold;

  assign in_hold = (state == HOLD);
  assign busy    = in_hold;
  // Lowest set request bit, and requests that outrank the current owner.
  assign win     = req & (~req + ONE_REQ);
  assign higher  = req & (grant - ONE_REQ);

  // Select the winning requester's codes and decimal points.
  always_comb begin
    win_data = '0;
    win_dp   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win[i]) begin
        win_data = req_data[i*DATA_W +: DATA_W];
        win_dp   = req_dp[i*NUM_DIGITS +: NUM_DIGITS];
      end
    end
  end

  seg_hold_timer #(.LIMIT(HOLD_CYCLES)) u_hold_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (hold_clr),
    .en      (in_hold),
    .expire  (hold_expire)
  );

`ifdef SEG_DISPLAY_ARBITER_BLINK_EN
  logic                  blink_q, phase_q, phase_n, blink_expire;
  logic [DATA_W-1:0]     snap_data;
  logic [NUM_DIGITS-1:0] snap_dp;

  seg_hold_timer #(.LIMIT(BLINK_HALF)) u_blink_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (hold_clr | blink_expire),
    .en      (in_hold & blink_q),
    .expire  (blink_expire)
  );

  // Latch the snapshot and blink request at grant; advance the blink phase.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      blink_q   <= 1'b0;
      phase_q   <= 1'b1;
      snap_data <= '0;
      snap_dp   <= '0;
    end else begin
      phase_q <= phase_n;
      if (take) begin
        blink_q   <= |(req_blink & win);
        snap_data <= win_data;
        snap_dp   <= win_dp;
      end
    end
  end
`else
  logic unused_blink;
  assign unused_blink = ^{req_blink, BLINK_HALF[0]};
`endif

  // Next state and next output values; expiry beats cancel beats preemption.
  always_comb begin
    state_n  = state;
    grant_n  = grant;
    done_n   = '0;
    seg_n    = seg_data;
    dp_n     = dp_data;
    take     = 1'b0;
    hold_clr = 1'b1;
`ifdef SEG_DISPLAY_ARBITER_BLINK_EN
    phase_n  = phase_q;
`endif
    unique case (state)
      IDLE: begin
        if (|req) begin
          take = 1'b1;
        end else begin
          seg_n = base_data;
          dp_n  = base_dp;
        end
      end
      HOLD: begin
        if (hold_expire) begin
          state_n = IDLE;
          done_n  = grant;
          grant_n = '0;
          seg_n   = base_data;
          dp_n    = base_dp;
        end else if (!(|(req & grant))) begin
          state_n = IDLE;
          grant_n = '0;
          seg_n   = base_data;
          dp_n    = base_dp;
        end else if (|higher) begin
          // The lowest set request is necessarily one of the higher ones.
          take = 1'b1;
        end else begin
          hold_clr = 1'b0;
`ifdef SEG_DISPLAY_ARBITER_BLINK_EN
          if (blink_q && blink_expire) begin
            phase_n = ~phase_q;
            seg_n   = phase_q ? BLANK_DATA : snap_data;
            dp_n    = phase_q ? '0 : snap_dp;
          end
`endif
        end
      end
      default: state_n = IDLE;
    endcase
    if (take) begin
      state_n = HOLD;
      grant_n = win;
      seg_n   = win_data;
      dp_n    = win_dp;
`ifdef SEG_DISPLAY_ARBITER_BLINK_EN
      phase_n = 1'b1;
`endif
    end
  end

  // Registered state and display outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      grant    <= '0;
      done     <= '0;
      seg_data <= BLANK_DATA;
      dp_data  <= '0;
    end else begin
      state    <= state_n;
      grant    <= grant_n;
      done     <= done_n;
      seg_data <= seg_n;
      dp_data  <= dp_n;
    end
  end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Self-checking bench for seg_display_arbiter with a cycle-level reference model.
module tb_seg_display_arbiter;

  localparam int unsigned HOLD = 8;
  localparam int unsigned BH   = 2;
`ifdef SEG_DISPLAY_ARBITER_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [19:0] base_data;
  logic [3:0]  base_dp;
  logic [2:0]  req, req_blink;
  logic [59:0] req_data;
  logic [11:0] req_dp;
  logic [2:0]  grant, done;
  logic        busy;
  logic [19:0] seg_data;
  logic [3:0]  dp_data;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int          m_owner = -1;
  int          m_elapsed = 0;
  logic        m_blink = 1'b0;
  logic [19:0] m_snap = '0;
  logic [3:0]  m_snapdp = '0;
  logic [2:0]  exp_grant = '0, exp_done = '0;
  logic        exp_busy = 1'b0;
  logic [19:0] exp_seg = 20'hFFFFF;
  logic [3:0]  exp_dp = '0;

  logic [30:0] dut_vec, exp_vec;
  assign dut_vec = {grant, done, busy, dp_data, seg_data};
  assign exp_vec = {exp_grant, exp_done, exp_busy, exp_dp, exp_seg};

  always #5 clk = ~clk;

  seg_display_arbiter #(.HOLD_CYCLES(HOLD), .BLINK_HALF(BH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .base_data (base_data),
    .base_dp   (base_dp),
    .req       (req),
    .req_data  (req_data),
    .req_dp    (req_dp),
    .req_blink (req_blink),
    .grant     (grant),
    .done      (done),
    .busy      (busy),
    .seg_data  (seg_data),
    .dp_data   (dp_data)
  );

  // Model: owner index and number of edges since it was granted.
  task automatic model_step();
    int   lo;
    logic take, show_base;
    lo = -1;
    for (int i = 2; i >= 0; i--) if (req[i]) lo = i;
    take      = 1'b0;
    show_base = 1'b0;
    exp_done  = '0;
    if (!reset_n) begin
      m_owner = -1;
      exp_seg = 20'hFFFFF;
      exp_dp  = '0;
    end else begin
      if (m_owner < 0) begin
        if (lo >= 0) take = 1'b1;
        else show_base = 1'b1;
      end else if (m_elapsed + 1 == HOLD) begin
        exp_done  = 3'(1 << m_owner);
        m_owner   = -1;
        show_base = 1'b1;
      end else if (!req[m_owner]) begin
        m_owner   = -1;
        show_base = 1'b1;
      end else if (lo < m_owner) begin
        take = 1'b1;
      end else begin
        m_elapsed++;
      end
      if (take) begin
        m_owner   = lo;
        m_elapsed = 0;
        m_snap    = req_data[20*lo +: 20];
        m_snapdp  = req_dp[4*lo +: 4];
        m_blink   = BLINK_ON && req_blink[lo];
      end
      if (show_base) begin
        exp_seg = base_data;
        exp_dp  = base_dp;
      end else if (m_blink && ((m_elapsed / BH) % 2 == 1)) begin
        exp_seg = 20'hFFFFF;
        exp_dp  = '0;
      end else begin
        exp_seg = m_snap;
        exp_dp  = m_snapdp;
      end
    end
    exp_grant = (m_owner < 0) ? 3'b000 : 3'(1 << m_owner);
    exp_busy  = (m_owner >= 0);
  endtask

  always @(posedge clk) model_step();

  task automatic randomize_data();
    base_data = 20'($urandom);
    base_dp   = 4'($urandom);
    req_data  = 60'({$urandom, $urandom});
    req_dp    = 12'($urandom);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if (seg_data !== 20'hFFFFF || dp_data !== 4'h0 || grant !== 3'b000 || done !== 3'b000 || busy !== 1'b0)
        $display("FAIL reset cyc%0d got seg=%h dp=%h grant=%b done=%b busy=%b required seg=fffff dp=0 grant=000 done=000 busy=0",
                 k, seg_data, dp_data, grant, done, busy);
      else n_pass++;
    end
    reset_n   = 1'b1;
    base_data = 20'h08421;
    @(posedge clk); #1;
    n_checks++;
    if (seg_data !== 20'h08421) $display("FAIL reset_base got %h required 08421", seg_data);
    else n_pass++;
    n_checks++;
    if (dut_vec !== exp_vec) $display("FAIL reset_model got %h required %h", dut_vec, exp_vec);
    else n_pass++;
  endtask

  task automatic test_single();
    randomize_data();
    req = 3'b010;
    req_data[39:20] = 20'h5A5A5;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if (dut_vec !== exp_vec) $display("FAIL single cyc%0d got %h required %h", k, dut_vec, exp_vec);
      else n_pass++;
      if (k <= 8) begin
        n_checks++;
        if (grant !== 3'b010 || seg_data !== 20'h5A5A5)
          $display("FAIL single_hold cyc%0d got grant=%b seg=%h required grant=010 seg=5a5a5", k, grant, seg_data);
        else n_pass++;
      end
      if (k == 9) begin
        n_checks++;
        if (done !== 3'b010 || grant !== 3'b000 || seg_data !== base_data)
          $display("FAIL single_done got done=%b grant=%b seg=%h required done=010 grant=000 seg=%h",
                   done, grant, seg_data, base_data);
        else n_pass++;
      end
      if (exp_done[1]) req[1] = 1'b0;
      randomize_data();
    end
  endtask

  task automatic test_preempt();
    req = 3'b100;
    for (int k = 1; k <= 24; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if (dut_vec !== exp_vec) $display("FAIL preempt cyc%0d got %h required %h", k, dut_vec, exp_vec);
      else n_pass++;
      if (k == 4 || k == 13 || k == 21) begin
        n_checks++;
        if ((k == 4  && (grant !== 3'b001 || done !== 3'b000)) ||
            (k == 13 && (grant !== 3'b100 || done !== 3'b000)) ||
            (k == 21 && (grant !== 3'b000 || done !== 3'b100)))
          $display("FAIL preempt_point cyc%0d got grant=%b done=%b", k, grant, done);
        else n_pass++;
      end
      if (k == 3) req[0] = 1'b1;
      req = req & ~exp_done;
      randomize_data();
    end
  endtask

  task automatic test_collision();
    req = 3'b010;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if (dut_vec !== exp_vec) $display("FAIL collision cyc%0d got %h required %h", k, dut_vec, exp_vec);
      else n_pass++;
      if (k == 9 || k == 10) begin
        n_checks++;
        if ((k == 9  && (done !== 3'b010 || grant !== 3'b000)) ||
            (k == 10 && (done !== 3'b000 || grant !== 3'b001)))
          $display("FAIL collision_point cyc%0d got grant=%b done=%b", k, grant, done);
        else n_pass++;
      end
      if (k == 8) req[0] = 1'b1;
      req = req & ~exp_done;
      randomize_data();
    end
  endtask

  task automatic test_cancel();
    req = 3'b001;
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if (dut_vec !== exp_vec) $display("FAIL cancel cyc%0d got %h required %h", k, dut_vec, exp_vec);
      else n_pass++;
      if (k == 4 || k == 9) begin
        n_checks++;
        if (grant !== 3'b000 || done !== 3'b000 || busy !== 1'b0 ||
            (k == 9 && (seg_data !== 20'hFFFFF || dp_data !== 4'h0)))
          $display("FAIL cancel_point cyc%0d got grant=%b done=%b busy=%b seg=%h dp=%h",
                   k, grant, done, busy, seg_data, dp_data);
        else n_pass++;
      end
      if (k == 3) req = 3'b000;
      if (k == 5) req = 3'b100;
      if (k == 8) reset_n = 1'b0;
      if (k == 9) begin
        reset_n = 1'b1;
        req     = 3'b000;
      end
      randomize_data();
    end
  endtask

  task automatic test_blink();
    logic [19:0] snap;
    logic [19:0] want;
    randomize_data();
    snap           = 20'h12345;
    req_data[19:0] = snap;
    req            = 3'b001;
    req_blink      = 3'b001;
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if (dut_vec !== exp_vec) $display("FAIL blink cyc%0d got %h required %h", k, dut_vec, exp_vec);
      else n_pass++;
      if (k <= 8) begin
        want = (BLINK_ON && (((k - 1) / 2) % 2 == 1)) ? 20'hFFFFF : snap;
        n_checks++;
        if (seg_data !== want) $display("FAIL blink_seg cyc%0d got %h required %h", k, seg_data, want);
        else n_pass++;
      end
      req = req & ~exp_done;
      randomize_data();
    end
    req_blink = 3'b000;
  endtask

  task automatic test_random();
    for (int k = 1; k <= 400; k++) begin
      for (int i = 0; i < 3; i++) begin
        if (req[i] && exp_done[i]) req[i] = 1'b0;
        else if (req[i] && $urandom_range(0, 24) == 0) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 5) == 0) req[i] = 1'b1;
      end
      req_blink = 3'($urandom);
      randomize_data();
      @(posedge clk); #1;
      n_checks++;
      if (dut_vec !== exp_vec) $display("FAIL random cyc%0d got %h required %h", k, dut_vec, exp_vec);
      else n_pass++;
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    req       = '0;
    req_blink = '0;
    base_data = '0;
    base_dp   = '0;
    req_data  = '0;
    req_dp    = '0;
    test_reset();
    test_single();
    test_preempt();
    test_collision();
    test_cancel();
    test_blink();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
